// File: rtl/piso_shift_tx.sv
// piso_shift_tx -- parallel-in / serial-out transmitter for a one-bit registered link.
//
// A WIDTH-bit word is accepted on a valid/ready handshake and sent one bit per clk
// on sout. The word is framed by sout_valid, frame_start and frame_end.
// If a word is accepted during the final cycle of a frame, the next frame follows
// with no gap.
//
// Optional feature: define PARITY_EN to append one even-parity bit to each frame.
// The frame is then WIDTH+1 cycles long.
//
// Parameters:
//   WIDTH      word length in bits (2..32)
//   LSB_FIRST  0: din[WIDTH-1] is sent first; 1: din[0] is sent first
// Ports:
//   clk          rising-edge clock
//   rst          synchronous reset, active-high
//   din          parallel word, captured on accept
//   load_valid   producer has a word on din
//   load_ready   transmitter can take a word this cycle (combinational)
//   sout         serial data bit (registered; 0 when idle)
//   sout_valid   sout carries a frame bit this cycle
//   frame_start  first data bit of a frame
//   frame_end    last bit of a frame (last data bit, or the parity bit)
//   busy         frame in progress (same as sout_valid)

module piso_shift_tx #(
   parameter int unsigned WIDTH     = 8,
   parameter int unsigned LSB_FIRST = 0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] din,
   input  logic             load_valid,
   output logic             load_ready,
   output logic             sout,
   output logic             sout_valid,
   output logic             frame_start,
   output logic             frame_end,
   output logic             busy
);

   localparam int unsigned     CNT_W    = $clog2(WIDTH);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

`ifdef PARITY_EN
   localparam bit HAS_PARITY = 1'b1;
   typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_PARITY} state_t;
`else
   localparam bit HAS_PARITY = 1'b0;
   typedef enum logic [1:0] {ST_IDLE, ST_SHIFT} state_t;
`endif

   state_t           state_q, state_d;
   logic [WIDTH-1:0] shreg_q, shreg_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             sout_q, sout_d;
   logic             sout_valid_q, sout_valid_d;
   logic             frame_start_q, frame_start_d;
   logic             frame_end_q, frame_end_d;
`ifdef PARITY_EN
   logic             parity_q, parity_d;
`endif

   logic             last_bit;
   logic             accept;
   logic [CNT_W-1:0] next_cnt;
   logic [WIDTH-1:0] shifted;

   // The bit on the wire always comes from the leading end of the shift register.
   function automatic logic lead_bit(input logic [WIDTH-1:0] w);
      if (LSB_FIRST != 0) return w[0];
      else                return w[WIDTH-1];
   endfunction

   function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] w);
      if (LSB_FIRST != 0) return w >> 1;
      else                return w << 1;
   endfunction

   assign last_bit = (state_q == ST_SHIFT) && (cnt_q == CNT_LAST);
   assign next_cnt = cnt_q + 1'b1;
   assign shifted  = advance(shreg_q);

`ifdef PARITY_EN
   assign load_ready = (state_q == ST_IDLE) || (state_q == ST_PARITY);
`else
   assign load_ready = (state_q == ST_IDLE) || last_bit;
`endif

   assign accept = load_valid && load_ready;

   always_comb begin
      state_d       = state_q;
      shreg_d       = shreg_q;
      cnt_d         = cnt_q;
      sout_d        = 1'b0;
      sout_valid_d  = 1'b0;
      frame_start_d = 1'b0;
      frame_end_d   = 1'b0;
`ifdef PARITY_EN
      parity_d      = parity_q;
`endif

      case (state_q)
         ST_IDLE: ;
         ST_SHIFT: begin
            if (!last_bit) begin
               cnt_d        = next_cnt;
               shreg_d      = shifted;
               sout_d       = lead_bit(shifted);
               sout_valid_d = 1'b1;
               frame_end_d  = !HAS_PARITY && (next_cnt == CNT_LAST);
            end else begin
`ifdef PARITY_EN
               state_d      = ST_PARITY;
               sout_d       = parity_q;
               sout_valid_d = 1'b1;
               frame_end_d  = 1'b1;
`else
               state_d      = ST_IDLE;
`endif
            end
         end
`ifdef PARITY_EN
         ST_PARITY: state_d = ST_IDLE;
`endif
         default: state_d = ST_IDLE;
      endcase

      // Accept is only possible in the frame-closing states, so a new word
      // simply overrides whatever those states would otherwise have done.
      if (accept) begin
         state_d       = ST_SHIFT;
         shreg_d       = din;
         cnt_d         = '0;
         sout_d        = lead_bit(din);
         sout_valid_d  = 1'b1;
         frame_start_d = 1'b1;
         frame_end_d   = 1'b0;
`ifdef PARITY_EN
         parity_d      = ^din;
`endif
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= ST_IDLE;
         shreg_q       <= '0;
         cnt_q         <= '0;
         sout_q        <= 1'b0;
         sout_valid_q  <= 1'b0;
         frame_start_q <= 1'b0;
         frame_end_q   <= 1'b0;
`ifdef PARITY_EN
         parity_q      <= 1'b0;
`endif
      end else begin
         state_q       <= state_d;
         shreg_q       <= shreg_d;
         cnt_q         <= cnt_d;
         sout_q        <= sout_d;
         sout_valid_q  <= sout_valid_d;
         frame_start_q <= frame_start_d;
         frame_end_q   <= frame_end_d;
`ifdef PARITY_EN
         parity_q      <= parity_d;
`endif
      end
   end

   assign sout        = sout_q;
   assign sout_valid  = sout_valid_q;
   assign frame_start = frame_start_q;
   assign frame_end   = frame_end_q;
   assign busy        = sout_valid_q;

endmodule
